// File: rtl/text_video_gen.sv
// Character-cell text video generator: raster timing, cell/glyph prefetch,
// attribute and cursor shaping, registered and mutually aligned video outputs.
module text_video_gen #(
    parameter int   ROWS         = 24,
    parameter int   COLS         = 80,
    parameter int   ROW_BITS     = 5,
    parameter int   COL_BITS     = 7,
    parameter int   ADDR_BITS    = 11,
    parameter int   CHAR_H       = 16,
    parameter int   PIX_DIV      = 2,
    parameter int   H_VIS        = 640,
    parameter int   H_FP         = 16,
    parameter int   H_SYNC       = 96,
    parameter int   H_BP         = 48,
    parameter int   V_VIS        = 384,
    parameter int   V_FP         = 20,
    parameter int   V_SYNC       = 2,
    parameter int   V_BP         = 43,
    parameter logic HSYNC_POL    = 1'b0,
    parameter logic VSYNC_POL    = 1'b1,
    parameter int   BLINK_FRAMES = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [ADDR_BITS-1:0]          first_char,
    input  logic [COL_BITS-1:0]           cursor_x,
    input  logic [ROW_BITS-1:0]           cursor_y,
    input  logic [1:0]                    cursor_mode,
    output logic [ADDR_BITS-1:0]          cell_raddr,
    input  logic [15:0]                   cell_rdata,
    output logic [8+$clog2(CHAR_H)-1:0]   font_addr,
    input  logic [7:0]                    font_data,
    output logic                          hsync,
    output logic                          vsync,
    output logic                          hblank,
    output logic                          vblank,
    output logic                          video,
    output logic                          dim,
    output logic                          frame_start
);

    localparam int H_TOT  = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT  = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int SL_W   = $clog2(CHAR_H);
    localparam int HC_W   = $clog2(H_TOT + 8);
    localparam int VC_W   = $clog2(V_TOT + 1);
    localparam int DIV_W  = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam int BC_W   = $clog2(BLINK_FRAMES + 1);

    localparam logic [HC_W-1:0]      H_TOT_C  = HC_W'(H_TOT);
    localparam logic [HC_W-1:0]      H_LAST   = HC_W'(H_TOT - 1);
    localparam logic [HC_W-1:0]      H_VIS_C  = HC_W'(H_VIS);
    localparam logic [HC_W-1:0]      HS_START = HC_W'(H_VIS + H_FP);
    localparam logic [HC_W-1:0]      HS_END   = HC_W'(H_VIS + H_FP + H_SYNC);
    localparam logic [VC_W-1:0]      V_LAST   = VC_W'(V_TOT - 1);
    localparam logic [VC_W-1:0]      V_VIS_C  = VC_W'(V_VIS);
    localparam logic [VC_W-1:0]      VS_START = VC_W'(V_VIS + V_FP);
    localparam logic [VC_W-1:0]      VS_END   = VC_W'(V_VIS + V_FP + V_SYNC);
    localparam logic [ADDR_BITS:0]   NCELLS   = (ADDR_BITS+1)'(ROWS * COLS);
    localparam logic [SL_W-1:0]      SL_LAST  = SL_W'(CHAR_H - 1);
    localparam logic [SL_W-1:0]      SL_ULINE = SL_W'(CHAR_H - 2);
    localparam logic [DIV_W-1:0]     DIV_LAST = DIV_W'(PIX_DIV - 1);
    localparam logic [BC_W-1:0]      BC_LAST  = BC_W'(BLINK_FRAMES - 1);

    logic [DIV_W-1:0]     div_cnt;
    logic                 pix_en;
    logic [HC_W-1:0]      hc;
    logic [VC_W-1:0]      vc;

    logic [ADDR_BITS-1:0] fc_r;
    logic [COL_BITS-1:0]  cx_r;
    logic [ROW_BITS-1:0]  cy_r;
    logic [1:0]           cm_r;
    logic                 phase;
    logic [BC_W-1:0]      blink_cnt;

    logic [HC_W-1:0]      fx_sum;
    logic [HC_W-1:0]      fx;
    logic [VC_W-1:0]      fv;
    logic                 fetch_vis;
    logic [2:0]           sub;
    logic [SL_W-1:0]      fsl;
    logic [ROW_BITS-1:0]  frow;
    logic [COL_BITS-1:0]  fcol;
    logic [ADDR_BITS-1:0] base;
    logic [ADDR_BITS:0]   addr_sum;
    logic [ADDR_BITS-1:0] fetch_addr;
    logic                 mode_inv;
    logic                 cursor_hit;

    logic                 ul_on;
    logic                 kill;
    logic                 inv;
    logic                 dim_next;
    logic [7:0]           glyph_next;
    logic [7:0]           cur_glyph;
    logic                 cur_dim;
    logic                 vis;

    logic                 unused_rdata;
    assign unused_rdata = ^cell_rdata[15:12];

    assign pix_en = (div_cnt == DIV_LAST);

    // Pixel clock divider: one pix_en every PIX_DIV clocks.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= {DIV_W{1'b0}};
        end else if (pix_en) begin
            div_cnt <= {DIV_W{1'b0}};
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // Raster position of the pixel presented at the next pix_en.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hc <= {HC_W{1'b0}};
            vc <= {VC_W{1'b0}};
        end else if (pix_en) begin
            if (hc == H_LAST) begin
                hc <= {HC_W{1'b0}};
                vc <= (vc == V_LAST) ? {VC_W{1'b0}} : vc + VC_W'(1);
            end else begin
                hc <= hc + HC_W'(1);
            end
        end
    end

    // Frame-level settings and blink phase, latched once per frame at the start of the
    // last (blank) line so the whole next frame, including its prefetch, sees one set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fc_r      <= {ADDR_BITS{1'b0}};
            cx_r      <= {COL_BITS{1'b0}};
            cy_r      <= {ROW_BITS{1'b0}};
            cm_r      <= 2'b00;
            phase     <= 1'b0;
            blink_cnt <= {BC_W{1'b0}};
        end else if (pix_en && (hc == {HC_W{1'b0}}) && (vc == V_LAST)) begin
            fc_r <= first_char;
            cx_r <= cursor_x;
            cy_r <= cursor_y;
            cm_r <= cursor_mode;
            if (blink_cnt == BC_LAST) begin
                blink_cnt <= {BC_W{1'b0}};
                phase     <= ~phase;
            end else begin
                blink_cnt <= blink_cnt + BC_W'(1);
            end
        end
    end

    // Fetch position runs one cell (8 pixels) ahead of the displayed pixel, wrapping
    // into the next line so the first cell is fetched during the preceding blanking.
    always_comb begin
        fx_sum = hc + HC_W'(8);
        if (fx_sum >= H_TOT_C) begin
            fx = fx_sum - H_TOT_C;
            fv = (vc == V_LAST) ? {VC_W{1'b0}} : vc + VC_W'(1);
        end else begin
            fx = fx_sum;
            fv = vc;
        end
        fetch_vis = (fx < H_VIS_C) && (fv < V_VIS_C);
        sub       = fx[2:0];
        fsl       = fv[SL_W-1:0];
        frow      = ROW_BITS'(fv >> SL_W);
        fcol      = COL_BITS'(fx >> 3);
    end

    // Cell address with scroll offset, wrapping modulo the screen size.
    always_comb begin
        if ({1'b0, fc_r} >= NCELLS) begin
            base = {ADDR_BITS{1'b0}};
        end else begin
            base = fc_r;
        end
        addr_sum = {1'b0, base} + (ADDR_BITS+1)'(int'(frow) * COLS) + (ADDR_BITS+1)'(fcol);
        if (addr_sum >= NCELLS) begin
            fetch_addr = ADDR_BITS'(addr_sum - NCELLS);
        end else begin
            fetch_addr = ADDR_BITS'(addr_sum);
        end
    end

    // Cursor inversion for the cell being fetched; out-of-range cursors never match.
    always_comb begin
        cursor_hit = (fcol == cx_r) && (frow == cy_r);
        case (cm_r)
            2'b01:   mode_inv = 1'b1;
            2'b10:   mode_inv = phase;
            2'b11:   mode_inv = phase && (fsl >= SL_ULINE);
            default: mode_inv = 1'b0;
        endcase
    end

    // Prefetch pipeline: RAM address, then attributes + font address, then shaped glyph.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cell_raddr <= {ADDR_BITS{1'b0}};
            font_addr  <= {(8+SL_W){1'b0}};
            ul_on      <= 1'b0;
            kill       <= 1'b0;
            inv        <= 1'b0;
            dim_next   <= 1'b0;
            glyph_next <= 8'h00;
        end else if (pix_en && fetch_vis) begin
            case (sub)
                3'd0: cell_raddr <= fetch_addr;
                3'd2: begin
                    font_addr <= {cell_rdata[7:0], fsl};
                    ul_on     <= cell_rdata[9] && (fsl == SL_LAST);
                    kill      <= cell_rdata[10] && !phase;
                    inv       <= cell_rdata[8] ^ (cursor_hit && mode_inv);
                    dim_next  <= cell_rdata[11];
                end
                3'd4: glyph_next <= (kill ? 8'h00 : (font_data | {8{ul_on}})) ^ {8{inv}};
                default: ;
            endcase
        end
    end

    // Hand the prefetched cell to the display stage on the last pixel of the current cell.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_glyph <= 8'h00;
            cur_dim   <= 1'b0;
        end else if (pix_en && (sub == 3'd7)) begin
            cur_glyph <= glyph_next;
            cur_dim   <= dim_next;
        end
    end

    assign vis = (hc < H_VIS_C) && (vc < V_VIS_C);

    // Registered outputs for pixel (hc,vc), all updated on the same pix_en.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hsync       <= ~HSYNC_POL;
            vsync       <= ~VSYNC_POL;
            hblank      <= 1'b1;
            vblank      <= 1'b1;
            video       <= 1'b0;
            dim         <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= pix_en && (hc == {HC_W{1'b0}}) && (vc == {VC_W{1'b0}});
            if (pix_en) begin
                hblank <= !(hc < H_VIS_C);
                vblank <= !(vc < V_VIS_C);
                hsync  <= ((hc >= HS_START) && (hc < HS_END)) ? HSYNC_POL : ~HSYNC_POL;
                vsync  <= ((vc >= VS_START) && (vc < VS_END)) ? VSYNC_POL : ~VSYNC_POL;
                video  <= vis && cur_glyph[3'd7 - hc[2:0]];
                dim    <= vis && cur_dim;
            end
        end
    end

endmodule
